// File: rtl/fpu_div_if.sv
// Operand/result handshake bundle for the sequential FP32 divider.
// The slave side is the divider; the master side is the issue logic.
interface fpu_div_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_float_A;
  logic [31:0] i_float_B;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_S;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_zero;
  logic        o_NaN;
  logic        o_div_by_zero;

  modport slave (
    input  i_valid, i_float_A, i_float_B, i_ready,
    output o_ready, o_valid, o_S,
    output o_overflow, o_underflow, o_zero,
    output o_NaN, o_div_by_zero
  );

  modport master (
    output i_valid, i_float_A, i_float_B, i_ready,
    input  o_ready, o_valid, o_S,
    input  o_overflow, o_underflow, o_zero,
    input  o_NaN, o_div_by_zero
  );
endinterface

// File: rtl/fpu_div_32bit_seq.sv
// FP32 divider S = A / B, one quotient bit per cycle (restoring).
// Denormals flush to zero; result mantissa is truncated.
module fpu_div_32bit_seq #(
  parameter int QBITS = 25
) (
  input logic      i_clk,
  input logic      i_rst_n,
  fpu_div_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [QBITS:0]      rem_q, rem_d;
  logic [23:0]         dvs_q, dvs_d;
  logic [QBITS-1:0]    quo_q, quo_d;
  logic [4:0]          cnt_q, cnt_d;
  logic signed [9:0]   exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [31:0]         s_q, s_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                zero_q, zero_d;
  logic                nan_q, nan_d;
  logic                dbz_q, dbz_d;

  logic [7:0]          a_exp, b_exp;
  logic [22:0]         a_frac, b_frac;
  logic                a_zero, b_zero;
  logic                a_inf, b_inf;
  logic                a_nan, b_nan;
  logic                sign_in;
  logic                ge;
  logic [QBITS:0]      sub;
  logic signed [9:0]   nexp;
  logic [22:0]         mant;

  assign a_exp   = bus.i_float_A[30:23];
  assign b_exp   = bus.i_float_B[30:23];
  assign a_frac  = bus.i_float_A[22:0];
  assign b_frac  = bus.i_float_B[22:0];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign sign_in = bus.i_float_A[31] ^ bus.i_float_B[31];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    nan_d   = nan_q;
    dbz_d   = dbz_q;

    ge   = (rem_q >= {2'b00, dvs_q});
    sub  = ge ? (rem_q - {2'b00, dvs_q}) : rem_q;
    // Q[24] set means the quotient is already in [1,2)
    nexp = quo_q[QBITS-1] ? exp_q : (exp_q - 10'sd1);
    mant = quo_q[QBITS-1] ? quo_q[23:1] : quo_q[22:0];

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          state_d = DONE;
          if (a_nan || b_nan || (a_zero && b_zero) ||
              (a_inf && b_inf)) begin
            s_d   = 32'h7FC0_0000;
            nan_d = 1'b1;
          end else if (a_inf) begin
            s_d   = {sign_in, 8'hFF, 23'd0};
            ovf_d = 1'b1;
          end else if (b_zero) begin
            s_d   = {sign_in, 8'hFF, 23'd0};
            ovf_d = 1'b1;
            dbz_d = 1'b1;
          end else if (a_zero || b_inf) begin
            s_d    = {sign_in, 31'd0};
            zero_d = 1'b1;
          end else begin
            state_d = DIVIDE;
            rem_d   = {2'b00, 1'b1, a_frac};
            dvs_d   = {1'b1, b_frac};
            quo_d   = '0;
            cnt_d   = 5'(QBITS - 1);
            exp_d   = $signed({2'b00, a_exp})
                    - $signed({2'b00, b_exp})
                    + 10'sd127;
            sign_d  = sign_in;
          end
        end
      end
      DIVIDE: begin
        rem_d = sub << 1;
        quo_d = {quo_q[QBITS-2:0], ge};
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      NORM: begin
        state_d = DONE;
        if (nexp >= 10'sd255) begin
          s_d   = {sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (nexp <= 10'sd0) begin
          s_d    = {sign_q, 31'd0};
          unf_d  = 1'b1;
          zero_d = 1'b1;
        end else begin
          s_d = {sign_q, nexp[7:0], mant};
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
          s_d     = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          nan_d   = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
      nan_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
      nan_q   <= nan_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.o_ready       = (state_q == IDLE);
  assign bus.o_valid       = (state_q == DONE);
  assign bus.o_S           = s_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = unf_q;
  assign bus.o_zero        = zero_q;
  assign bus.o_NaN         = nan_q;
  assign bus.o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_fpu_div_32bit_seq.sv
// Directed bench for fpu_div_32bit_seq: hand-computed quotients,
// flags, latency, backpressure and mid-operation reset.
module tb_fpu_div_32bit_seq;
  logic i_clk;
  logic i_rst_n;
  int   checks;
  int   passes;

  fpu_div_if bus ();

  fpu_div_32bit_seq dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] flags();
    return {27'd0, bus.o_div_by_zero, bus.o_NaN,
            bus.o_zero, bus.o_underflow, bus.o_overflow};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issues one operand pair and returns cycles until o_valid.
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       output int lat);
    bus.i_valid   = 1'b1;
    bus.i_float_A = a;
    bus.i_float_B = b;
    step();
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(bus.o_valid), 32'd0);
    check({tag, " ready_back"}, 32'(bus.o_ready), 32'd1);
  endtask

  task automatic do_op(input string tag,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp_s,
                       input logic [4:0] exp_f,
                       input int exp_lat);
    int lat;
    check({tag, " ready_in"}, 32'(bus.o_ready), 32'd1);
    issue(a, b, lat);
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " S"}, bus.o_S, exp_s);
    check({tag, " flags"}, flags(), {27'd0, exp_f});
    check({tag, " busy"}, 32'(bus.o_ready), 32'd0);
    release_result(tag);
  endtask

  initial begin
    int lat;
    checks        = 0;
    passes        = 0;
    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_float_A = '0;
    bus.i_float_B = '0;
    i_rst_n       = 1'b0;
    #12;
    check("rst valid", 32'(bus.o_valid), 32'd0);
    check("rst ready", 32'(bus.o_ready), 32'd1);
    check("rst S", bus.o_S, 32'd0);
    check("rst flags", flags(), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    // flags field order: {dbz, nan, zero, unf, ovf}
    do_op("6/2", 32'h40C0_0000, 32'h4000_0000,
          32'h4040_0000, 5'b00000, 27);
    do_op("1/3", 32'h3F80_0000, 32'h4040_0000,
          32'h3EAA_AAAA, 5'b00000, 27);
    do_op("-6/2", 32'hC0C0_0000, 32'h4000_0000,
          32'hC040_0000, 5'b00000, 27);
    do_op("1/0", 32'h3F80_0000, 32'h0000_0000,
          32'h7F80_0000, 5'b10001, 1);
    do_op("0/0", 32'h0000_0000, 32'h0000_0000,
          32'h7FC0_0000, 5'b01000, 1);
    do_op("nan/1", 32'h7FC0_0001, 32'h3F80_0000,
          32'h7FC0_0000, 5'b01000, 1);
    do_op("inf/inf", 32'h7F80_0000, 32'hFF80_0000,
          32'h7FC0_0000, 5'b01000, 1);
    do_op("inf/2", 32'hFF80_0000, 32'h4000_0000,
          32'hFF80_0000, 5'b00001, 1);
    do_op("2/inf", 32'h4000_0000, 32'h7F80_0000,
          32'h0000_0000, 5'b00100, 1);
    do_op("ovf", 32'h7F00_0000, 32'h3E80_0000,
          32'h7F80_0000, 5'b00001, 27);
    do_op("unf", 32'h0080_0000, 32'h4000_0000,
          32'h0000_0000, 5'b00110, 27);
    do_op("-0/2", 32'h8000_0000, 32'h4000_0000,
          32'h8000_0000, 5'b00100, 1);

    // Hold the result while a new operand pair is offered.
    issue(32'h40C0_0000, 32'h4000_0000, lat);
    check("bp lat", 32'(lat), 32'd27);
    bus.i_valid   = 1'b1;
    bus.i_float_A = 32'h3F80_0000;
    bus.i_float_B = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp valid", 32'(bus.o_valid), 32'd1);
      check("bp ready", 32'(bus.o_ready), 32'd0);
      check("bp S", bus.o_S, 32'h4040_0000);
      check("bp flags", flags(), 32'd0);
    end
    bus.i_valid = 1'b0;
    release_result("bp");

    // Reset ten cycles into DIVIDE drops the operation.
    bus.i_valid   = 1'b1;
    bus.i_float_A = 32'h3F80_0000;
    bus.i_float_B = 32'h4040_0000;
    step();
    bus.i_valid = 1'b0;
    repeat (9) step();
    check("mid busy", 32'(bus.o_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    check("mrst valid", 32'(bus.o_valid), 32'd0);
    check("mrst ready", 32'(bus.o_ready), 32'd1);
    check("mrst S", bus.o_S, 32'd0);
    check("mrst flags", flags(), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    check("post ready", 32'(bus.o_ready), 32'd1);
    repeat (30) step();
    check("post stale", 32'(bus.o_valid), 32'd0);
    do_op("6/2 again", 32'h40C0_0000, 32'h4000_0000,
          32'h4040_0000, 5'b00000, 27);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
